// File: rtl/audio_out_mixer_pkg.sv
// Shared types and constants for the speaker output mixer.
`timescale 1ns/1ps
package audio_pkg;

    localparam int unsigned CLK_HZ = 25_175_000;

    // Source indices in priority order (0 = highest)
    localparam int unsigned SRC_DEATH = 0;
    localparam int unsigned SRC_WIN   = 1;
    localparam int unsigned SRC_JUMP  = 2;
    localparam int unsigned SRC_MUSIC = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } mix_state_t;

endpackage

// File: rtl/audio_out_mixer_if.sv
// Tone sources, volume/mute controls and speaker-side status of the mixer.
`timescale 1ns/1ps
interface audio_out_mixer_if #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned PWM_BITS = 4
);
    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]  src_tone;
    logic [NUM_SRC-1:0]  src_active;
    logic [PWM_BITS-1:0] volume;
    logic                mute;
    logic                speaker_out;
    logic [SRC_W-1:0]    active_src;
    logic                busy;

    modport master (
        output src_tone, src_active, volume, mute,
        input  speaker_out, active_src, busy
    );

    modport slave (
        input  src_tone, src_active, volume, mute,
        output speaker_out, active_src, busy
    );
endinterface

// File: rtl/audio_out_mixer_pwm_gate.sv
// Free-running PWM counter and volume compare producing the output gate.
`timescale 1ns/1ps
module pwm_gate #(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] volume,
    output logic                gate
);
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pwm_cnt_q <= '0;
        else          pwm_cnt_q <= pwm_cnt_d;
    end

    // Full-scale volume bypasses the compare so the tone is never chopped
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        gate      = (&volume) | (pwm_cnt_q < volume);
    end
endmodule

// File: rtl/audio_out_mixer.sv
// Priority-selects one tone source, switches glitch-free through a silent gap,
// and drives the speaker pin with PWM volume gating and mute.
`timescale 1ns/1ps
module audio_out_mixer
    import audio_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned PWM_BITS   = 4,
    parameter int unsigned GAP_CYCLES = 25_175
) (
    input  logic             clk,
    input  logic             reset_n,
    audio_out_mixer_if.slave bus
);
    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    mix_state_t         state_q, state_d;
    logic [SRC_W-1:0]   cur_q, cur_d;
    logic [SRC_W-1:0]   active_src_q, active_src_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_SRC-1:0] tone_r_q, active_r_q;
    logic               speaker_q, speaker_d;
    logic               busy_q, busy_d;
    logic               gate;
    logic               win_valid;
    logic [SRC_W-1:0]   win;

    pwm_gate #(.PWM_BITS(PWM_BITS)) u_pwm_gate (
        .clk     (clk),
        .reset_n (reset_n),
        .volume  (bus.volume),
        .gate    (gate)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            active_src_q <= '0;
            gap_cnt_q    <= '0;
            tone_r_q     <= '0;
            active_r_q   <= '0;
            speaker_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            active_src_q <= active_src_d;
            gap_cnt_q    <= gap_cnt_d;
            tone_r_q     <= bus.src_tone;
            active_r_q   <= bus.src_active;
            speaker_q    <= speaker_d;
            busy_q       <= busy_d;
        end
    end

    // Lowest active index wins
    always_comb begin
        win_valid = |active_r_q;
        win       = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (active_r_q[i]) win = SRC_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        active_src_d = active_src_q;
        gap_cnt_d    = '0;
        speaker_d    = (state_q == PLAY) & tone_r_q[cur_q] & gate;
        busy_d       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (!bus.mute && win_valid) begin
                    state_d      = PLAY;
                    cur_d        = win;
                    active_src_d = win;
                end
            end
            PLAY: begin
                if (bus.mute) begin
                    state_d = IDLE;
                end else if (!active_r_q[cur_q]) begin
                    state_d = win_valid ? GAP : IDLE;
                // Preempt only on a low level so the current tone never gets a runt pulse
                end else if (win_valid && (win < cur_q) && !tone_r_q[cur_q]) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (bus.mute) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (win_valid) begin
                        state_d      = PLAY;
                        cur_d        = win;
                        active_src_d = win;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.speaker_out = speaker_q;
    assign bus.active_src  = active_src_q;
    assign bus.busy        = busy_q;
endmodule
